// File: rtl/core.sv
// rtl/core.sv - single-cycle RV32I + Zicsr machine-mode core with unified word memory.
// Optional retire trace under CORE_TRACE_EN.
module core_mem #(
    parameter int MEM_WORDS = 65536
) (
    input  logic        clk,
    input  logic [15:0] iaddr,
    output logic [31:0] idata,
    input  logic [15:0] daddr,
    output logic [31:0] ddata,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata
);
    logic [31:0] m [0:MEM_WORDS-1];

    assign idata = m[iaddr];
    assign ddata = m[daddr];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) m[daddr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end
endmodule

module core #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 65536
) (
    input logic clk,
    input logic rst
);
    localparam logic [31:0] MISA = 32'h4000_0100;

    logic [31:0] pc;
    logic [31:0] rs  [0:31];
    logic [31:0] csr [0:31];

    logic [31:0] insn, ddata, wdata;
    logic [3:0]  wstrb;
    logic [17:0] daddr;

    core_mem #(.MEM_WORDS(MEM_WORDS)) memory (
        .clk   (clk),
        .iaddr (pc[17:2]),
        .idata (insn),
        .daddr (daddr[17:2]),
        .ddata (ddata),
        .wstrb (rst ? 4'b0000 : wstrb),
        .wdata (wdata)
    );

    logic [6:0]  opcode;
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] v1, v2, imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = insn[6:0];
    assign rd     = insn[11:7];
    assign f3     = insn[14:12];
    assign r1     = insn[19:15];
    assign r2     = insn[24:20];
    assign alt    = insn[30];
    assign v1     = (r1 == 5'd0) ? 32'd0 : rs[r1];
    assign v2     = (r2 == 5'd0) ? 32'd0 : rs[r2];
    assign imm_i  = {{20{insn[31]}}, insn[31:20]};
    assign imm_s  = {{20{insn[31]}}, insn[31:25], insn[11:7]};
    assign imm_b  = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    assign imm_u  = {insn[31:12], 12'd0};
    assign imm_j  = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
    assign daddr  = 18'(v1 + ((opcode == 7'h23) ? imm_s : imm_i));

    // CSR address decode; unmapped addresses read 0 and never write.
    logic [4:0]  cidx;
    logic        cmap, cro;
    logic [31:0] cold;
    always_comb begin
        cidx = 5'd0;
        cmap = 1'b1;
        cro  = 1'b0;
        case (insn[31:20])
            12'h300: cidx = 5'd0;
            12'h301: begin cidx = 5'd1; cro = 1'b1; end
            12'h304: cidx = 5'd2;
            12'h305: cidx = 5'd3;
            12'h340: cidx = 5'd4;
            12'h341: cidx = 5'd5;
            12'h342: cidx = 5'd6;
            12'h343: cidx = 5'd7;
            12'h344: cidx = 5'd8;
            12'hF14: begin cidx = 5'd9; cro = 1'b1; end
            default: cmap = 1'b0;
        endcase
    end
    assign cold = cmap ? csr[cidx] : 32'd0;

    logic [31:0] alu_b, alu_y;
    logic [4:0]  shamt;
    always_comb begin
        alu_b = (opcode == 7'h33) ? v2 : imm_i;
        shamt = alu_b[4:0];
        case (f3)
            3'd0:    alu_y = (opcode == 7'h33 && alt) ? v1 - alu_b : v1 + alu_b;
            3'd1:    alu_y = v1 << shamt;
            3'd2:    alu_y = {31'd0, $signed(v1) < $signed(alu_b)};
            3'd3:    alu_y = {31'd0, v1 < alu_b};
            3'd4:    alu_y = v1 ^ alu_b;
            3'd5:    alu_y = alt ? 32'($signed(v1) >>> shamt) : v1 >> shamt;
            3'd6:    alu_y = v1 | alu_b;
            default: alu_y = v1 & alu_b;
        endcase
    end

    logic [7:0]  lbyte;
    logic [15:0] lhalf;
    logic [31:0] ld_val;
    logic        take;
    assign lbyte = ddata[{daddr[1:0], 3'b000} +: 8];
    assign lhalf = daddr[1] ? ddata[31:16] : ddata[15:0];
    always_comb begin
        case (f3)
            3'd0:    ld_val = {{24{lbyte[7]}}, lbyte};
            3'd1:    ld_val = {{16{lhalf[15]}}, lhalf};
            3'd4:    ld_val = {24'd0, lbyte};
            3'd5:    ld_val = {16'd0, lhalf};
            default: ld_val = ddata;
        endcase
        case (f3)
            3'd0:    take = (v1 == v2);
            3'd1:    take = (v1 != v2);
            3'd4:    take = ($signed(v1) < $signed(v2));
            3'd5:    take = ($signed(v1) >= $signed(v2));
            3'd6:    take = (v1 < v2);
            3'd7:    take = (v1 >= v2);
            default: take = 1'b0;
        endcase
    end

    logic [31:0] pc_next, rd_val, csr_new, csr_src, cause, tval;
    logic        rd_we, csr_we, trap, mret;
    always_comb begin
        pc_next = pc + 32'd4;
        rd_we   = 1'b0;
        rd_val  = alu_y;
        csr_we  = 1'b0;
        csr_new = 32'd0;
        csr_src = f3[2] ? {27'd0, r1} : v1;
        wstrb   = 4'b0000;
        wdata   = v2;
        trap    = 1'b0;
        mret    = 1'b0;
        cause   = 32'd0;
        tval    = 32'd0;
        case (opcode)
            7'h37: begin rd_we = 1'b1; rd_val = imm_u; end
            7'h17: begin rd_we = 1'b1; rd_val = pc + imm_u; end
            7'h6F: begin rd_we = 1'b1; rd_val = pc + 32'd4; pc_next = pc + imm_j; end
            7'h67: begin rd_we = 1'b1; rd_val = pc + 32'd4; pc_next = (v1 + imm_i) & ~32'd1; end
            7'h63: if (take) pc_next = pc + imm_b;
            7'h03: begin rd_we = 1'b1; rd_val = ld_val; end
            7'h23: begin
                case (f3)
                    3'd0: begin wstrb = 4'b0001 << daddr[1:0]; wdata = {4{v2[7:0]}}; end
                    3'd1: begin wstrb = daddr[1] ? 4'b1100 : 4'b0011; wdata = {2{v2[15:0]}}; end
                    3'd2: wstrb = 4'b1111;
                    default: wstrb = 4'b0000;
                endcase
            end
            7'h13, 7'h33: rd_we = 1'b1;
            7'h0F: ;
            7'h73: begin
                if (f3 == 3'd0) begin
                    // SRET/WFI and other privileged encodings fall through as no-ops.
                    case (insn[31:20])
                        12'h000: begin trap = 1'b1; cause = 32'd11; end
                        12'h001: begin trap = 1'b1; cause = 32'd3; end
                        12'h302: begin mret = 1'b1; pc_next = csr[5]; end
                        default: ;
                    endcase
                end else if (f3 != 3'd4) begin
                    rd_we  = 1'b1;
                    rd_val = cold;
                    csr_we = cmap && !cro && (f3[1:0] == 2'b01 || r1 != 5'd0);
                    case (f3[1:0])
                        2'b01:   csr_new = csr_src;
                        2'b10:   csr_new = cold | csr_src;
                        default: csr_new = cold & ~csr_src;
                    endcase
                end
            end
            default: begin trap = 1'b1; cause = 32'd2; tval = insn; end
        endcase
        if (trap) begin
            rd_we   = 1'b0;
            pc_next = csr[3] & ~32'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++) begin
                rs[i]  <= 32'd0;
                csr[i] <= 32'd0;
            end
            csr[1] <= MISA;
        end else begin
            pc <= pc_next;
            if (rd_we && rd != 5'd0) rs[rd] <= rd_val;
            if (csr_we) csr[cidx] <= csr_new;
            if (trap) begin
                csr[0] <= {csr[0][31:8], csr[0][3], csr[0][6:4], 1'b0, csr[0][2:0]};
                csr[5] <= pc;
                csr[6] <= cause;
                csr[7] <= tval;
            end
            if (mret) csr[0] <= {csr[0][31:8], 1'b1, csr[0][6:4], csr[0][7], csr[0][2:0]};
        end
    end

`ifdef CORE_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (rd_we && rd != 5'd0) $display("pc=%08h insn=%08h x%0d=%08h", pc, insn, rd, rd_val);
            else                     $display("pc=%08h insn=%08h", pc, insn);
        end
    end
`else
    // Trace disabled: no simulation output and no extra logic.
`endif
endmodule

// File: tb/tb_core.sv
// tb/tb_core.sv - scoreboard bench for core: directed programs plus a random program run on an op-level model.
module tb_core;
    logic clk = 1'b0;
    logic rst = 1'b1;

    core dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    // kind: 0 pc, 1 register, 2 memory word, 3 csr
    typedef struct { int tag; int kind; int idx; logic [31:0] val; } item_t;
    item_t q[$];
    int edge_cnt = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge clk) edge_cnt++;

    task automatic check(input item_t it);
        logic [31:0] act;
        string nm;
        case (it.kind)
            0:       begin act = dut.pc;                nm = "pc"; end
            1:       begin act = dut.rs[it.idx];        nm = $sformatf("x%0d", it.idx); end
            2:       begin act = dut.memory.m[it.idx];  nm = $sformatf("m[%0d]", it.idx); end
            default: begin act = dut.csr[it.idx];       nm = $sformatf("csr%0d", it.idx); end
        endcase
        n_cmp++;
        if (act !== it.val) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %08h expected %08h", nm, it.tag, act, it.val);
        end
    endtask

    always @(negedge clk) begin
        item_t it;
        while (q.size() > 0 && q[0].tag <= edge_cnt) begin
            it = q.pop_front();
            check(it);
        end
    end

    task automatic want(input int kind, input int idx, input logic [31:0] val);
        q.push_back('{edge_cnt + 1, kind, idx, val});
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- assembler ----------------
    function automatic logic [31:0] e_r(input int f7, input int r2, input int r1, input int f3, input int rd, input int op);
        return {f7[6:0], r2[4:0], r1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] e_i(input int imm, input int r1, input int f3, input int rd, input int op);
        return {imm[11:0], r1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] e_s(input int imm, input int r2, input int r1, input int f3);
        return {imm[11:5], r2[4:0], r1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] e_b(input int imm, input int r2, input int r1, input int f3);
        return {imm[12], imm[10:5], r2[4:0], r1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] e_u(input int imm, input int rd, input int op);
        return {imm[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] e_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction

    logic [31:0] mm [0:2047];

    task automatic put(input int addr, input logic [31:0] w);
        dut.memory.m[addr >> 2] = w;
        mm[addr >> 2] = w;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) put(i * 4, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        want(0, 0, 32'h0);
        want(3, 0, 32'h0);
        want(3, 1, 32'h4000_0100);
        want(3, 9, 32'h0);
        tick();
        rst = 1'b0;
    endtask

    // ---------------- op-level reference model ----------------
    localparam int R_OP = 0, I_OP = 1, SH_I = 2, LUI = 3, AUIPC = 4,
                   LD = 5, ST = 6, BR = 7, JAL = 8, JALR = 9;
    typedef struct { int cls; int f3; int alt; int rd; int rs1; int rs2; int imm; } op_t;
    op_t prog [0:255];
    logic [31:0] xr [0:31];
    logic [31:0] mpc;
    int i_f3 [6] = '{0, 2, 3, 4, 6, 7};
    int l_f3 [5] = '{0, 1, 2, 4, 5};
    int b_f3 [6] = '{0, 1, 4, 5, 6, 7};

    function automatic logic [31:0] alu(input int f3, input int alt, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            0:       return alt ? a - b : a + b;
            1:       return a << b[4:0];
            2:       return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3:       return (a < b) ? 32'd1 : 32'd0;
            4:       return a ^ b;
            5:       return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            6:       return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [31:0] enc(input op_t o);
        int f7 = o.alt ? 32 : 0;
        case (o.cls)
            R_OP:    return e_r(f7, o.rs2, o.rs1, o.f3, o.rd, 7'h33);
            I_OP:    return e_i(o.imm, o.rs1, o.f3, o.rd, 7'h13);
            SH_I:    return e_i(f7 * 32 + o.imm, o.rs1, o.f3, o.rd, 7'h13);
            LUI:     return e_u(o.imm, o.rd, 7'h37);
            AUIPC:   return e_u(o.imm, o.rd, 7'h17);
            LD:      return e_i(o.imm, o.rs1, o.f3, o.rd, 7'h03);
            ST:      return e_s(o.imm, o.rs2, o.rs1, o.f3);
            BR:      return e_b(o.imm, o.rs2, o.rs1, o.f3);
            JAL:     return e_j(o.imm, o.rd);
            default: return e_i(o.imm, o.rs1, 0, o.rd, 7'h67);
        endcase
    endfunction

    task automatic model_step();
        op_t o;
        logic [31:0] a, b, r, npc, addr, w, bt, hf;
        bit wr, tk;
        o = prog[mpc[9:2]];
        a = xr[o.rs1];
        b = xr[o.rs2];
        npc = mpc + 4;
        addr = a + 32'(o.imm);
        r = 32'd0;
        wr = 1'b0;
        case (o.cls)
            R_OP:  begin wr = 1; r = alu(o.f3, o.alt, a, b); end
            I_OP:  begin wr = 1; r = alu(o.f3, 0, a, 32'(o.imm)); end
            SH_I:  begin wr = 1; r = alu(o.f3, o.alt, a, 32'(o.imm)); end
            LUI:   begin wr = 1; r = 32'(o.imm) << 12; end
            AUIPC: begin wr = 1; r = mpc + (32'(o.imm) << 12); end
            LD: begin
                wr = 1;
                w  = mm[addr[12:2]];
                bt = w >> (8 * addr[1:0]);
                hf = w >> (16 * addr[1]);
                case (o.f3)
                    0:       r = {{24{bt[7]}}, bt[7:0]};
                    1:       r = {{16{hf[15]}}, hf[15:0]};
                    4:       r = {24'd0, bt[7:0]};
                    5:       r = {16'd0, hf[15:0]};
                    default: r = w;
                endcase
            end
            ST: begin
                w = mm[addr[12:2]];
                case (o.f3)
                    0:       w[8 * addr[1:0] +: 8] = b[7:0];
                    1:       w[16 * addr[1] +: 16] = b[15:0];
                    default: w = b;
                endcase
                mm[addr[12:2]] = w;
                want(2, int'(addr[12:2]), w);
            end
            BR: begin
                case (o.f3)
                    0:       tk = (a == b);
                    1:       tk = (a != b);
                    4:       tk = ($signed(a) < $signed(b));
                    5:       tk = ($signed(a) >= $signed(b));
                    6:       tk = (a < b);
                    default: tk = (a >= b);
                endcase
                if (tk) npc = mpc + 32'(o.imm);
            end
            JAL:     begin wr = 1; r = mpc + 4; npc = mpc + 32'(o.imm); end
            default: begin wr = 1; r = mpc + 4; npc = addr & ~32'd1; end
        endcase
        if (wr) begin
            if (o.rd != 0) xr[o.rd] = r;
            want(1, o.rd, xr[o.rd]);
        end
        want(0, 0, npc);
        mpc = npc;
    endtask

    task automatic gen_prog(input int np);
        op_t o;
        prog[0] = '{I_OP, 0, 0, 31, 0, 0, 'h400};
        for (int i = 1; i < np - 1; i++) begin
            o.cls = (i >= np - 3) ? R_OP : int'($urandom_range(0, 9));
            o.rd  = $urandom_range(0, 30);
            o.rs1 = $urandom_range(0, 31);
            o.rs2 = $urandom_range(0, 31);
            o.f3  = 0;
            o.alt = 0;
            o.imm = 0;
            case (o.cls)
                R_OP: begin
                    o.f3  = $urandom_range(0, 7);
                    o.alt = (o.f3 == 0 || o.f3 == 5) ? int'($urandom_range(0, 1)) : 0;
                end
                I_OP: begin
                    o.f3  = i_f3[$urandom_range(0, 5)];
                    o.imm = int'($urandom_range(0, 4095)) - 2048;
                end
                SH_I: begin
                    o.f3  = $urandom_range(0, 1) ? 5 : 1;
                    o.alt = (o.f3 == 5) ? int'($urandom_range(0, 1)) : 0;
                    o.imm = $urandom_range(0, 31);
                end
                LUI, AUIPC: o.imm = $urandom_range(0, 20'hFFFFF);
                LD: begin o.f3 = l_f3[$urandom_range(0, 4)]; o.rs1 = 31; o.imm = $urandom_range(0, 1023); end
                ST: begin o.f3 = $urandom_range(0, 2); o.rs1 = 31; o.imm = $urandom_range(0, 1023); end
                BR: begin o.f3 = b_f3[$urandom_range(0, 5)]; o.imm = 8; end
                JAL: o.imm = 8;
                default: begin o.rs1 = 0; o.imm = i * 4 + 9; end
            endcase
            prog[i] = o;
        end
        prog[np - 1] = '{JAL, 0, 0, 0, 0, 0, 0};
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // addi and write to x0
        clear_mem();
        put(32'h00, e_i(5, 0, 0, 1, 7'h13));
        put(32'h04, e_i(7, 0, 0, 0, 7'h13));
        do_reset();
        want(1, 1, 32'd5); want(0, 0, 32'h4); tick();
        want(1, 0, 32'd0); want(0, 0, 32'h8); tick();

        // stores, loads, byte lanes
        clear_mem();
        put(32'h00, e_u('h12345, 1, 7'h37));
        put(32'h04, e_i('h678, 1, 0, 1, 7'h13));
        put(32'h08, e_s('h100, 1, 0, 2));
        put(32'h0C, e_i('h101, 0, 0, 2, 7'h03));
        put(32'h10, e_i(-1, 0, 0, 3, 7'h13));
        put(32'h14, e_s('h102, 3, 0, 0));
        put(32'h18, e_i('h102, 0, 5, 4, 7'h03));
        put(32'h1C, e_i('h102, 0, 0, 6, 7'h03));
        do_reset();
        want(1, 1, 32'h1234_5000); want(0, 0, 32'h4); tick();
        want(1, 1, 32'h1234_5678); tick();
        want(2, 64, 32'h1234_5678); tick();
        want(1, 2, 32'h0000_0056); tick();
        want(1, 3, 32'hFFFF_FFFF); tick();
        want(2, 64, 32'h12FF_5678); tick();
        want(1, 4, 32'h0000_12FF); tick();
        want(1, 6, 32'hFFFF_FFFF); want(0, 0, 32'h20); tick();

        // ecall / mret
        clear_mem();
        put(32'h00, e_i('h40, 0, 0, 1, 7'h13));
        put(32'h04, e_i('h305, 1, 1, 0, 7'h73));
        put(32'h08, e_j('h18, 0));
        put(32'h20, 32'h0000_0073);
        put(32'h40, e_i('h342, 0, 2, 6, 7'h73));
        put(32'h44, 32'h3020_0073);
        do_reset();
        want(1, 1, 32'h40); tick();
        want(3, 3, 32'h40); want(0, 0, 32'h8); tick();
        want(0, 0, 32'h20); tick();
        want(0, 0, 32'h40); want(3, 5, 32'h20); want(3, 6, 32'd11); want(3, 0, 32'h0); tick();
        want(1, 6, 32'd11); want(0, 0, 32'h44); tick();
        want(0, 0, 32'h20); want(3, 0, 32'h80); tick();

        // illegal opcode, read-only CSR, ebreak
        clear_mem();
        put(32'h00, e_i('h300, 8, 6, 0, 7'h73));
        put(32'h04, e_i('h305, 16, 5, 0, 7'h73));
        put(32'h08, 32'h0000_028B);
        put(32'h10, e_i('h301, 0, 1, 0, 7'h73));
        put(32'h14, e_i('h301, 0, 2, 8, 7'h73));
        put(32'h18, 32'h0010_0073);
        do_reset();
        want(3, 0, 32'h8); want(0, 0, 32'h4); tick();
        want(3, 3, 32'h10); tick();
        want(0, 0, 32'h10); want(3, 5, 32'h8); want(3, 6, 32'd2);
        want(3, 7, 32'h28B); want(3, 0, 32'h80); want(1, 5, 32'h0); tick();
        want(3, 1, 32'h4000_0100); want(0, 0, 32'h14); tick();
        want(1, 8, 32'h4000_0100); tick();
        want(0, 0, 32'h10); want(3, 6, 32'd3); want(3, 5, 32'h18); want(3, 0, 32'h0); tick();

        // branches, then reset pulse aborting a store
        clear_mem();
        put(32'h00, e_j('h10, 0));
        put(32'h10, e_b(-8, 0, 0, 0));
        put(32'h08, e_j('h10, 0));
        put(32'h18, e_i(-1, 0, 0, 1, 7'h13));
        put(32'h1C, e_i(1, 0, 0, 2, 7'h13));
        put(32'h20, e_b(16, 2, 1, 6));
        put(32'h24, e_b(8, 2, 1, 7));
        put(32'h2C, e_b(8, 2, 1, 4));
        put(32'h34, e_s('h200, 1, 0, 2));
        do_reset();
        want(0, 0, 32'h10); tick();
        want(0, 0, 32'h08); tick();
        want(0, 0, 32'h18); tick();
        want(1, 1, 32'hFFFF_FFFF); tick();
        want(1, 2, 32'h1); tick();
        want(0, 0, 32'h24); tick();
        want(0, 0, 32'h2C); tick();
        want(0, 0, 32'h34); tick();
        rst = 1'b1;
        want(0, 0, 32'h0);
        for (int r = 1; r < 32; r++) want(1, r, 32'h0);
        want(2, 128, 32'h0);
        want(2, 13, mm[13]);
        tick();
        rst = 1'b0;
        want(0, 0, 32'h10); tick();

        // random program against the op-level model
        for (int run = 0; run < 3; run++) begin
            clear_mem();
            for (int i = 256; i < 512; i++) put(i * 4, $urandom);
            gen_prog(150);
            for (int i = 0; i < 150; i++) put(i * 4, enc(prog[i]));
            for (int i = 0; i < 32; i++) xr[i] = 32'd0;
            mpc = 32'd0;
            do_reset();
            for (int s = 0; s < 170; s++) begin
                model_step();
                tick();
            end
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/core.md
CORE -- requirements
Module: core

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch address after reset.
REQ-002 Parameter MEM_WORDS, default 65536, number of 32-bit words in unified memory.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 No other ports; the bench loads program and data through the hierarchy and observes state through it.
REQ-006 Hierarchy: memory instance named memory with array m[0:MEM_WORDS-1] of 32 bits; register file array rs[0:31] of 32 bits; CSR array csr[0:31] of 32 bits; program counter reg pc.

Function
REQ-007 RV32I base ISA, single-cycle: exactly one instruction retires per rising clk edge when rst is low.
REQ-008 Fetch and load reads are combinational from m; stores write m on the rising edge.
REQ-009 Word index is addr[17:2], so addresses wrap modulo 256 KiB; m[i] holds bytes 4i..4i+3, little-endian, byte 4i in bits 7:0.
REQ-010 LB/LBU select the byte by addr[1:0]; LH/LHU select the halfword by addr[1]; LW ignores addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-011 SB/SH use byte-lane write enables and leave other bytes unchanged; SW ignores addr[1:0].
REQ-012 rs[0] always reads 0; writes to x0 are discarded.
REQ-013 Branches and JAL/JALR use 32-bit wrap-around arithmetic; JALR target is (rs1+imm) & ~1; JAL/JALR write pc+4 to rd.
REQ-014 Shifts use rs2[4:0] or shamt; SRA/SRAI are arithmetic; SLT/SLTU compare signed/unsigned.
REQ-015 FENCE and FENCE.I execute as no-ops.
REQ-016 Zicsr CSRRW/S/C and immediate forms; CSRRS/C with rs1=x0 or zimm=0 do not write the CSR.
REQ-017 CSR map (csr index <- address): 0 mstatus 0x300, 1 misa 0x301 (read-only 0x40000100), 2 mie 0x304, 3 mtvec 0x305, 4 mscratch 0x340, 5 mepc 0x341, 6 mcause 0x342, 7 mtval 0x343, 8 mip 0x344, 9 mhartid 0xF14 (read-only 0).
REQ-018 Unmapped CSR addresses read 0 and ignore writes, with no trap.
REQ-019 Traps: ECALL gives mcause=11, EBREAK gives mcause=3, undefined opcode gives mcause=2 with mtval=instruction.
REQ-020 On any trap: mepc=pc, mstatus.MPIE=MIE, MIE=0, pc=mtvec & ~3; rd is not written.
REQ-021 MRET: pc=mepc, MIE=MPIE, MPIE=1.
REQ-022 Machine mode only: no interrupts and no address translation; SRET and WFI execute as no-ops.

Reset
REQ-023 While rst=1 at a rising edge: pc=RESET_PC, all rs and csr entries 0 except the read-only values, and no memory write.
REQ-024 Memory contents are preserved across reset.
REQ-025 Reset asserted mid-program aborts the current instruction with no architectural side effects.

Configuration
REQ-026 Macro CORE_TRACE_EN: when defined, each retired instruction $displays pc, instruction, and rd/value if written.
REQ-027 Without CORE_TRACE_EN, no simulation output is generated and the datapath is identical.

Verification
REQ-028 m[0]=0x00500093 (addi x1,x0,5), one cycle after reset -> rs[1]=5, pc=4.
REQ-029 addi x0,x0,7 -> rs[0] stays 0.
REQ-030 x1=0x12345678, sw x1,0x100(x0) then lb x2,0x101(x0) -> m[64]=0x12345678, rs[2]=0x00000056; sb of 0xFF at 0x102 -> m[64]=0x12FF5678.
REQ-031 mtvec=0x40, ecall at pc=0x20 -> next pc=0x40, mepc=0x20, mcause=11; subsequent mret -> pc=0x20.
REQ-032 beq with taken offset -8 at pc=0x10 -> pc=0x08; bltu with x1=0xFFFFFFFF, x2=1 -> not taken.
REQ-033 rst pulsed high for one cycle mid-run -> pc=0 and rs[1..31]=0 on the next edge, with memory unchanged.
